// File: rtl/lfsr13_prbs_checker.sv
// Receive-side checker for the 13-bit LFSR PRBS stream: self-synchronises, then flywheels on its own
// prediction and reports every mismatched bit, with error/bit counters and a once-per-period tick.
module lfsr13_prbs_checker #(
    parameter logic [12:0] TAPS      = 13'h100D,
    parameter int unsigned LOCK_CNT  = 32,
    parameter int unsigned WINDOW    = 1024,
    parameter int unsigned ERR_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic        lock_lost,
    output logic        period_tick,
    output logic [15:0] err_count,
    output logic [31:0] bits_checked
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [7:0]  LOCK_N   = 8'(LOCK_CNT);
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] ERR_LIM  = 16'(ERR_LIMIT);
    localparam logic [12:0] SEQ_LAST = 13'd8190;

    function automatic logic predict_bit(input logic [12:0] h);
        return ^(h & TAPS);
    endfunction

    state_e      state_q, state_d;
    logic [12:0] hist_q, hist_d;
    logic [3:0]  fill_q, fill_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [15:0] win_err_q, win_err_d;
    logic [12:0] seq_cnt_q, seq_cnt_d;
    logic [15:0] err_count_q, err_count_d;
    logic [31:0] bits_checked_q, bits_checked_d;
    logic        locked_q, err_pulse_q, lock_lost_q, period_tick_q;
    logic        err_pulse_d, lock_lost_d, period_tick_d;

    logic        pred_s;
    logic        miss_s;
    logic [7:0]  match_inc_s;
    logic [15:0] win_err_inc_s;
    logic [15:0] err_next_s;
    logic [31:0] bits_next_s;

    // Next-state logic for the search/flywheel machine and the measurement counters.
    always_comb begin
        state_d        = state_q;
        hist_d         = hist_q;
        fill_d         = fill_q;
        match_cnt_d    = match_cnt_q;
        win_cnt_d      = win_cnt_q;
        win_err_d      = win_err_q;
        seq_cnt_d      = seq_cnt_q;
        err_next_s     = err_count_q;
        bits_next_s    = bits_checked_q;
        err_pulse_d    = 1'b0;
        lock_lost_d    = 1'b0;
        period_tick_d  = 1'b0;
        pred_s         = predict_bit(hist_q);
        miss_s         = bit_in ^ pred_s;
        match_inc_s    = match_cnt_q + 8'd1;
        win_err_inc_s  = win_err_q + {15'd0, miss_s};

        if (bit_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[11:0], bit_in};
                    if (fill_q < 4'd13) begin
                        fill_d = fill_q + 4'd1;
                    end else if (miss_s || (hist_q == 13'd0)) begin
                        match_cnt_d = 8'd0;
                    end else if (match_inc_s == LOCK_N) begin
                        match_cnt_d = match_inc_s;
                        state_d     = LOCKED;
                        seq_cnt_d   = 13'd0;
                        win_cnt_d   = 16'd0;
                        win_err_d   = 16'd0;
                    end else begin
                        match_cnt_d = match_inc_s;
                    end
                end
                LOCKED: begin
                    // Shift the prediction so a single line error cannot corrupt later predictions.
                    hist_d      = {hist_q[11:0], pred_s};
                    bits_next_s = (bits_checked_q == 32'hFFFF_FFFF) ? bits_checked_q
                                                                    : bits_checked_q + 32'd1;
                    if (miss_s) begin
                        err_pulse_d = 1'b1;
                        err_next_s  = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
                    end else begin
                        err_next_s  = err_count_q;
                    end
                    if (seq_cnt_q == SEQ_LAST) begin
                        period_tick_d = 1'b1;
                        seq_cnt_d     = 13'd0;
                    end else begin
                        seq_cnt_d     = seq_cnt_q + 13'd1;
                    end
                    if (win_err_inc_s >= ERR_LIM) begin
                        state_d     = SEARCH;
                        lock_lost_d = 1'b1;
                        fill_d      = 4'd0;
                        match_cnt_d = 8'd0;
                        win_cnt_d   = 16'd0;
                        win_err_d   = 16'd0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d   = 16'd0;
                        win_err_d   = 16'd0;
                    end else begin
                        win_cnt_d   = win_cnt_q + 16'd1;
                        win_err_d   = win_err_inc_s;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        err_count_d    = clear_cnt ? 16'd0 : err_next_s;
        bits_checked_d = clear_cnt ? 32'd0 : bits_next_s;
    end

    // State, counter and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SEARCH;
            hist_q         <= 13'd0;
            fill_q         <= 4'd0;
            match_cnt_q    <= 8'd0;
            win_cnt_q      <= 16'd0;
            win_err_q      <= 16'd0;
            seq_cnt_q      <= 13'd0;
            err_count_q    <= 16'd0;
            bits_checked_q <= 32'd0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            period_tick_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hist_q         <= hist_d;
            fill_q         <= fill_d;
            match_cnt_q    <= match_cnt_d;
            win_cnt_q      <= win_cnt_d;
            win_err_q      <= win_err_d;
            seq_cnt_q      <= seq_cnt_d;
            err_count_q    <= err_count_d;
            bits_checked_q <= bits_checked_d;
            locked_q       <= (state_d == LOCKED);
            err_pulse_q    <= err_pulse_d;
            lock_lost_q    <= lock_lost_d;
            period_tick_q  <= period_tick_d;
        end
    end

    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign lock_lost    = lock_lost_q;
    assign period_tick  = period_tick_q;
    assign err_count    = err_count_q;
    assign bits_checked = bits_checked_q;

endmodule

// File: tb/tb_lfsr13_prbs_checker.sv
// Directed bench for lfsr13_prbs_checker: a reference PRBS generator feeds clean or corrupted bits
// and each scenario task compares outputs against hand-derived expectations.
module tb_lfsr13_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked, err_pulse, lock_lost, period_tick;
    logic [15:0] err_count;
    logic [31:0] bits_checked;

    int n_tests = 0;
    int n_fail  = 0;
    int ep_cnt, ll_cnt, pt_cnt, lk_cnt;
    logic [12:0] g = 13'h1ACE;

    always #5 clk = ~clk;

    lfsr13_prbs_checker dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .period_tick(period_tick),
        .err_count(err_count), .bits_checked(bits_checked)
    );

    task automatic step(input logic b, input logic v, input logic clr);
        bit_in = b; bit_valid = v; clear_cnt = clr;
        @(posedge clk); #1;
        if (err_pulse === 1'b1) ep_cnt++;
        if (lock_lost === 1'b1) ll_cnt++;
        if (period_tick === 1'b1) pt_cnt++;
        if (locked === 1'b1) lk_cnt++;
    endtask

    // s[n] = s[n-1] ^ s[n-3] ^ s[n-4] ^ s[n-13]; g[0] is the newest bit.
    task automatic send(input logic inv, input logic v, input logic clr);
        logic b;
        if (v) begin
            b = g[0] ^ g[2] ^ g[3] ^ g[12];
            g = {g[11:0], b};
            step(b ^ inv, 1'b1, clr);
        end else begin
            step(1'($urandom_range(1, 0)), 1'b0, clr);
        end
    endtask

    task automatic clr_flags();
        ep_cnt = 0; ll_cnt = 0; pt_cnt = 0; lk_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 45; i++) send(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({locked, err_pulse, lock_lost, period_tick} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {locked, err_pulse, lock_lost, period_tick});
        end
        n_tests++;
        if (err_count !== 16'd0 || bits_checked !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts: err=%0d bits=%0d expected 0/0", err_count, bits_checked);
        end
    endtask

    task automatic test_lock();
        do_reset(); clr_flags();
        for (int i = 0; i < 44; i++) send(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (lk_cnt != 0 || locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_early: locked cycles=%0d expected 0 before bit 45", lk_cnt);
        end
        send(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_rise: locked=%b expected 1 after 45 bits", locked);
        end
        n_tests++;
        if (bits_checked !== 32'd0) begin
            n_fail++; $display("FAIL lock_bits: bits_checked=%0d expected 0", bits_checked);
        end
    endtask

    task automatic test_period();
        int steps;
        clr_flags(); steps = 0;
        while (pt_cnt == 0 && steps < 8300) begin
            send(1'b0, 1'b1, 1'b0);
            steps++;
        end
        n_tests++;
        if (steps != 8191 || bits_checked !== 32'd8191) begin
            n_fail++; $display("FAIL period_tick: tick after %0d bits (bits_checked=%0d) expected 8191", steps, bits_checked);
        end
        n_tests++;
        if (ep_cnt != 0 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL clean_errors: pulses=%0d err_count=%0d expected 0", ep_cnt, err_count);
        end
        send(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (period_tick !== 1'b0) begin
            n_fail++; $display("FAIL period_width: period_tick=%b expected 0", period_tick);
        end
    endtask

    task automatic test_single_error();
        clr_flags();
        send(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            n_fail++; $display("FAIL single_err: pulse=%b err_count=%0d locked=%b expected 1/1/1", err_pulse, err_count, locked);
        end
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (ep_cnt != 1 || err_pulse !== 1'b0 || err_count !== 16'd1) begin
            n_fail++; $display("FAIL single_err_once: pulses=%0d err_count=%0d expected 1/1", ep_cnt, err_count);
        end
    endtask

    task automatic test_lock_loss();
        do_reset(); lock_up(); clr_flags();
        for (int k = 0; k < 16; k++) begin
            send(1'b1, 1'b1, 1'b0);
            if (k < 15) for (int j = 0; j < 9; j++) send(1'b0, 1'b1, 1'b0);
            if (k == 14) begin
                n_tests++;
                if (locked !== 1'b1 || ll_cnt != 0) begin
                    n_fail++; $display("FAIL loss_early: locked=%b lost=%0d expected 1/0 after 15 errors", locked, ll_cnt);
                end
            end
        end
        n_tests++;
        if (lock_lost !== 1'b1 || locked !== 1'b0 || err_count !== 16'd16) begin
            n_fail++; $display("FAIL loss_16th: lost=%b locked=%b err_count=%0d expected 1/0/16", lock_lost, locked, err_count);
        end
        for (int i = 0; i < 44; i++) send(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (locked !== 1'b0 || ll_cnt != 1) begin
            n_fail++; $display("FAIL relock_early: locked=%b lost pulses=%0d expected 0/1", locked, ll_cnt);
        end
        send(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (locked !== 1'b1 || err_count !== 16'd16) begin
            n_fail++; $display("FAIL relock: locked=%b err_count=%0d expected 1/16", locked, err_count);
        end
    endtask

    task automatic test_two_windows();
        do_reset(); lock_up(); clr_flags();
        for (int i = 0; i < 1100; i++) send((i >= 1009 && i <= 1038), 1'b1, 1'b0);
        n_tests++;
        if (ll_cnt != 0 || locked !== 1'b1) begin
            n_fail++; $display("FAIL split_windows: lost=%0d locked=%b expected 0/1", ll_cnt, locked);
        end
        n_tests++;
        if (err_count !== 16'd30 || ep_cnt != 30 || bits_checked !== 32'd1100) begin
            n_fail++; $display("FAIL split_counts: err=%0d pulses=%0d bits=%0d expected 30/30/1100", err_count, ep_cnt, bits_checked);
        end
    endtask

    task automatic test_all_zero();
        do_reset(); clr_flags();
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (lk_cnt != 0 || ep_cnt != 0) begin
            n_fail++; $display("FAIL all_zero: locked cycles=%0d pulses=%0d expected 0/0", lk_cnt, ep_cnt);
        end
    endtask

    task automatic test_gated_valid();
        do_reset(); clr_flags();
        for (int i = 0; i < 89; i++) send(1'b0, (i % 2) == 0, 1'b0);
        n_tests++;
        if (lk_cnt != 1 || locked !== 1'b1) begin
            n_fail++; $display("FAIL gated_lock: locked cycles=%0d locked=%b expected 1/1", lk_cnt, locked);
        end
        for (int i = 0; i < 21; i++) send(1'b0, (i % 2) == 1, 1'b0);
        n_tests++;
        if (bits_checked !== 32'd10 || locked !== 1'b1) begin
            n_fail++; $display("FAIL gated_bits: bits_checked=%0d expected 10", bits_checked);
        end
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (err_pulse !== 1'b0 || ep_cnt != 1 || err_count !== 16'd1 || bits_checked !== 32'd11) begin
            n_fail++; $display("FAIL gated_err: pulse=%b pulses=%0d err=%0d bits=%0d expected 0/1/1/11", err_pulse, ep_cnt, err_count, bits_checked);
        end
    endtask

    task automatic test_clear();
        send(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (err_count !== 16'd0 || bits_checked !== 32'd0) begin
            n_fail++; $display("FAIL clear_wins: err=%0d bits=%0d expected 0/0", err_count, bits_checked);
        end
        send(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (err_count !== 16'd0 || bits_checked !== 32'd1) begin
            n_fail++; $display("FAIL after_clear: err=%0d bits=%0d expected 0/1", err_count, bits_checked);
        end
    endtask

    task automatic test_reset_locked();
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_lock: locked=%b expected 1", locked);
        end
        rst = 1'b1;
        send(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        n_tests++;
        if ({locked, err_pulse, lock_lost, period_tick} !== 4'b0000 || err_count !== 16'd0 || bits_checked !== 32'd0) begin
            n_fail++; $display("FAIL reset_locked: flags=%b err=%0d bits=%0d expected 0000/0/0",
                               {locked, err_pulse, lock_lost, period_tick}, err_count, bits_checked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_period();
        test_single_error();
        test_lock_loss();
        test_two_windows();
        test_all_zero();
        test_gated_valid();
        test_clear();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
